clm_encoder: RTL and testbench
==============================

Name: clm_encoder

Overview:
- Entry stage of the CLM datapath. It converts a plain GF(2^8) byte into a masked CLM state (8+d coefficients), which is the form the CLM multiplier takes on its p1/p2 operands.
- The d random redundancy coefficients r come from an internal LFSR, and the low byte is corrected through the systematic encoder matrix B_ext.
- Valid/ready handshake on both sides, with a single registered output slot.

Parameters:
- d, 4, number of redundancy coefficients. Range 1..16.
- LFSR_W, 32, LFSR width. Must be ≥ d.
- SEED_DEFAULT, 32'h0000_0001, LFSR value at reset and on a zero-seed load. Must be nonzero.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  byte available
- in_ready  out  1  encoder can accept a byte
- in_byte  in  [7:0]  plain byte; bit i = coefficient of x^i
- out_valid  out  1  encoded state available
- out_ready  in  1  consumer accepts the state
- out_state  out  [0:7+d]  encoded state (state_t); bit i = coefficient of x^i
- B_ext  in  mul_m_matrix_t  systematic encoder matrix, rows 0..d-1 used; quasi-static
- seed_valid  in  1  load LFSR
- seed  in  [LFSR_W-1:0]  new LFSR value
- test_mode  in  1  force r = 0 (unmasked encoding)
- enc_count  out  [15:0]  number of accepted bytes, saturating

Behaviour:
- Reset (async, rst=1):
  - out_valid=0, out_state='0, enc_count=0, lfsr=SEED_DEFAULT.
  - Any held output is discarded.
- Accept condition: in_valid && in_ready.
  - in_ready = !out_valid || out_ready. This is combinational and permits a full-throughput pipeline.
- Latency: 1 cycle. An accept in cycle N gives out_valid=1 with the new out_state in cycle N+1.
- Output hold:
  - While out_valid && !out_ready, out_state and out_valid are stable and the LFSR holds.
  - out_valid clears on a handshake with no simultaneous accept.
- Redundancy r[j]:
  - r[j] = lfsr[j] for j<d, sampled on the accept cycle.
  - r = 0 if test_mode=1 on that cycle.
- Encoding:
  - out_state[8+j] = r[j].
  - out_state[i] = in_byte[i] XOR (XOR over j<d of r[j] & B_ext[j][i]), for i in 0..7.
- LFSR:
  - Fibonacci, taps for x^32+x^22+x^2+x+1 at LFSR_W=32: fb = l[31]^l[21]^l[1]^l[0]; next = {l[30:0], fb}.
  - Steps exactly once per accept, also when test_mode=1. Otherwise holds.
- Seed load:
  - seed_valid=1 loads seed next cycle; seed==0 loads SEED_DEFAULT instead.
  - Seed load has priority over stepping.
  - An accept in the same cycle uses the pre-load r.
- enc_count increments on each accept and saturates at 16'hFFFF.
- Simultaneous accept and output handshake: the output register is overwritten with the new byte and out_valid stays 1.
- B_ext changes only while out_valid=0 and no accept is in progress. Otherwise the result is unspecified.

Test Plan:
- d=4, B_ext=0, after reset: send 0x53, then 0x00 back-to-back with out_ready=1.
  - Cycle 1 out_state = bits 0,1,4,6 set, bit 8 set (r=0001).
  - Cycle 2 out_state = bit 8 and bit 9 set (lfsr=0x3); enc_count=2.
- B_ext[0][0]=B_ext[0][2]=1, other entries 0, after reset, byte 0x00 → out_state bits 0, 2, 8 set.
- test_mode=1, byte 0xA5, any B_ext → out_state[0:7]=0xA5 bits, r part 0.
  - The LFSR still steps: the next non-test byte uses r=0011.
- Backpressure: out_ready=0 for 5 cycles with in_valid=1.
  - in_ready=0 and out_state is stable.
  - The LFSR does not advance.
  - On release, exactly one transfer per handshake and no byte is lost or duplicated.
- seed_valid with seed=0 → next r = 0001. With seed=0x0000_000F and an accept in the same cycle, that byte uses the old r and the following byte uses r=1111.
- rst asserted mid-stream while out_valid=1: out_valid drops immediately, enc_count=0, and the first post-reset byte uses r=0001.

Source files
------------

// File: rtl/clm_encoder_if.sv
// Byte-in / masked-state-out handshake bundle for the CLM encoder.
// The slave modport is the encoder side, the master modport is its environment.
interface clm_encoder_if #(
    parameter int d = 4
);
    logic           in_valid;
    logic           in_ready;
    logic [7:0]     in_byte;
    logic           out_valid;
    logic           out_ready;
    logic [0:7+d]   out_state;

    modport master (
        output in_valid,
        output in_byte,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_state
    );

    modport slave (
        input  in_valid,
        input  in_byte,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_state
    );
endinterface

// File: rtl/clm_encoder.sv
// CLM entry stage: masks a plain GF(2^8) byte into an (8+d)-coefficient CLM state,
// drawing the d redundancy coefficients from an internal Fibonacci LFSR.
module clm_encoder #(
    parameter int                d            = 4,
    parameter int                LFSR_W       = 32,
    parameter logic [LFSR_W-1:0] SEED_DEFAULT = LFSR_W'(1)
) (
    input  logic                  clk,
    input  logic                  rst,
    clm_encoder_if.slave          bus,
    input  logic [d-1:0][7:0]     B_ext,
    input  logic                  seed_valid,
    input  logic [LFSR_W-1:0]     seed,
    input  logic                  test_mode,
    output logic [15:0]           enc_count
);

    // Taps follow x^32+x^22+x^2+x+1; the middle tap is pulled in for narrower registers.
    localparam int TAP_MID = (LFSR_W > 22) ? 21 : (LFSR_W / 2);

    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] lfsr_next;
    logic              fb;
    logic [d-1:0]      r;
    logic              accept;
    logic [0:7+d]      enc_state;
    logic              out_valid_q;
    logic [0:7+d]      out_state_q;

    assign bus.in_ready  = !out_valid_q || bus.out_ready;
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_state = out_state_q;

    assign r         = test_mode ? '0 : lfsr[d-1:0];
    assign fb        = lfsr[LFSR_W-1] ^ lfsr[TAP_MID] ^ lfsr[1] ^ lfsr[0];
    assign lfsr_next = {lfsr[LFSR_W-2:0], fb};

    always_comb begin
        logic acc;
        enc_state = '0;
        acc       = 1'b0;
        for (int j = 0; j < d; j++) begin
            enc_state[8+j] = r[j];
        end
        for (int i = 0; i < 8; i++) begin
            acc = bus.in_byte[i];
            for (int j = 0; j < d; j++) begin
                acc = acc ^ (r[j] & B_ext[j][i]);
            end
            enc_state[i] = acc;
        end
    end

    // A new accept overwrites the slot even when the old state leaves in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_state_q <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_state_q <= enc_state;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= SEED_DEFAULT;
        end else if (seed_valid) begin
            lfsr <= (seed == '0) ? SEED_DEFAULT : seed;
        end else if (accept) begin
            lfsr <= lfsr_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enc_count <= '0;
        end else if (accept && (enc_count != 16'hFFFF)) begin
            enc_count <= enc_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_clm_encoder.sv
// Self-checking bench for clm_encoder: directed scenarios plus randomized traffic
// against a cycle-level reference model and an in-order output scoreboard.
module tb_clm_encoder;

    localparam int          d            = 4;
    localparam int          LFSR_W       = 32;
    localparam logic [31:0] SEED_DEFAULT = 32'h0000_0001;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [d-1:0][7:0]   b_ext;
    logic                seed_valid;
    logic [31:0]         seed;
    logic                test_mode;
    logic [15:0]         enc_count;

    int n_compared   = 0;
    int n_mismatched = 0;

    bit                  m_valid;
    logic [31:0]         m_state;
    int                  m_count;
    logic [31:0]         m_lfsr;
    logic [31:0]         sb_q[$];

    always #5 clk = ~clk;

    clm_encoder_if #(.d(d)) bus ();

    clm_encoder #(
        .d(d),
        .LFSR_W(LFSR_W),
        .SEED_DEFAULT(SEED_DEFAULT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave),
        .B_ext(b_ext),
        .seed_valid(seed_valid),
        .seed(seed),
        .test_mode(test_mode),
        .enc_count(enc_count)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Polynomial view of the LFSR: feedback is the parity of the tapped bits.
    function automatic logic [31:0] model_lfsr_step(input logic [31:0] l);
        return {l[30:0], ^(l & 32'h8020_0003)};
    endfunction

    // Numeric state with bit i = coefficient of x^i: r sits above the corrected byte.
    function automatic logic [31:0] model_encode(input logic [7:0] b, input logic [d-1:0] r,
                                                 input logic [d-1:0][7:0] m);
        logic [7:0] mask = 8'h00;
        for (int j = 0; j < d; j++) begin
            if (r[j]) mask = mask ^ m[j];
        end
        return (32'(r) << 8) | 32'(b ^ mask);
    endfunction

    function automatic logic [31:0] to_num(input logic [0:7+d] st);
        logic [31:0] v = '0;
        for (int i = 0; i < 8 + d; i++) v[i] = st[i];
        return v;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_state = '0;
        m_count = 0;
        m_lfsr  = SEED_DEFAULT;
        sb_q.delete();
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_byte   = 8'h00;
        bus.out_ready = 1'b1;
        test_mode     = 1'b0;
        seed_valid    = 1'b0;
        seed          = '0;
    endtask

    // One clock cycle: drive at the falling edge, check combinational ready, then
    // advance the model across the rising edge and check the registered outputs.
    task automatic applyStimulus(input bit iv, input logic [7:0] ib, input bit ordy,
                                 input bit tm, input bit sv, input logic [31:0] sd);
        bit          acc;
        bit          exp_ready;
        logic [31:0] exp_enc;
        logic [31:0] head;
        @(negedge clk);
        bus.in_valid  = iv;
        bus.in_byte   = ib;
        bus.out_ready = ordy;
        test_mode     = tm;
        seed_valid    = sv;
        seed          = sd;
        #1;
        exp_ready = !m_valid || ordy;
        checkOutput("in_ready", 32'(bus.in_ready), 32'(exp_ready));
        if (bus.out_valid && ordy) begin
            checkOutput("sb_depth", 32'(sb_q.size()), 32'd1);
            if (sb_q.size() > 0) begin
                head = sb_q.pop_front();
                checkOutput("sb_handshake", to_num(bus.out_state), head);
            end
        end
        acc     = iv && exp_ready;
        exp_enc = model_encode(ib, tm ? '0 : m_lfsr[d-1:0], b_ext);
        @(posedge clk);
        #1;
        if (acc) begin
            m_valid = 1'b1;
            m_state = exp_enc;
            if (m_count < 65535) m_count++;
            sb_q.push_back(exp_enc);
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        if (sv) m_lfsr = (sd == 0) ? SEED_DEFAULT : sd;
        else if (acc) m_lfsr = model_lfsr_step(m_lfsr);
        checkOutput("out_valid", 32'(bus.out_valid), 32'(m_valid));
        if (m_valid) checkOutput("out_state", to_num(bus.out_state), m_state);
        checkOutput("enc_count", 32'(enc_count), 32'(m_count));
    endtask

    // Reset is raised mid-cycle so its asynchronous effect is visible before any edge.
    task automatic doReset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        #1;
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_enc_count", 32'(enc_count), 32'd0);
        checkOutput("rst_out_state", to_num(bus.out_state), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic setMatrix(input logic [d-1:0][7:0] mtx);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'd0);
        b_ext = mtx;
    endtask

    initial begin
        logic [d-1:0][7:0] mtx;
        idle_inputs();
        b_ext = '0;
        model_reset();

        doReset();
        applyStimulus(1'b1, 8'h53, 1'b1, 1'b0, 1'b0, 32'd0);
        checkOutput("tp_first_state", to_num(bus.out_state), 32'h153);
        applyStimulus(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 32'd0);
        checkOutput("tp_second_state", to_num(bus.out_state), 32'h300);
        checkOutput("tp_count_two", 32'(enc_count), 32'd2);

        doReset();
        mtx    = '0;
        mtx[0] = 8'h05;
        setMatrix(mtx);
        applyStimulus(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 32'd0);
        checkOutput("tp_matrix_row0", to_num(bus.out_state), 32'h105);

        doReset();
        for (int j = 0; j < d; j++) mtx[j] = 8'($urandom);
        setMatrix(mtx);
        applyStimulus(1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 32'd0);
        checkOutput("tp_test_mode", to_num(bus.out_state), 32'h0A5);
        setMatrix('0);
        applyStimulus(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 32'd0);
        checkOutput("tp_after_test_mode", to_num(bus.out_state), 32'h300);

        applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0, 32'd0);
        repeat (5) applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0, 32'd0);
        repeat (4) applyStimulus(1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0, 32'd0);

        setMatrix('0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 32'd0);
        applyStimulus(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 32'd0);
        checkOutput("tp_zero_seed", to_num(bus.out_state), 32'h100);
        applyStimulus(1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 32'h0000_000F);
        checkOutput("tp_seed_old_r", to_num(bus.out_state), 32'h300);
        applyStimulus(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 32'd0);
        checkOutput("tp_seed_new_r", to_num(bus.out_state), 32'hF00);

        applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0, 32'd0);
        doReset();
        applyStimulus(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 32'd0);
        checkOutput("tp_post_reset_r", to_num(bus.out_state), 32'h100);

        for (int n = 0; n < 400; n++) begin
            if (n % 64 == 63) begin
                for (int j = 0; j < d; j++) mtx[j] = 8'($urandom);
                setMatrix(mtx);
            end
            applyStimulus(bit'($urandom_range(0, 9) < 7), 8'($urandom),
                          bit'($urandom_range(0, 9) < 7), bit'($urandom_range(0, 9) == 0),
                          bit'($urandom_range(0, 29) == 0),
                          ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom));
        end

        checkOutput("sb_final_depth", 32'(sb_q.size()), m_valid ? 32'd1 : 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
